// File: rtl/seg7_scan_display.sv
// Hex viewer for one of two 32-bit CPU buses on an 8-digit multiplexed, active-low,
// common-anode display. Captured values reach the display only at frame boundaries.
module seg7_scan_display #(
  parameter int SCAN_DIV = 50000,
  parameter bit BLANK_LZ = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic        src_sel,
  input  logic [32:1] data_a,
  input  logic [32:1] data_b,
  output logic [8:1]  an,
  output logic [8:1]  seg,
  output logic        frame_done
);

  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

  logic [DIV_W-1:0] div;
  logic [2:0]       idx;
  logic [32:1]      pend_val;
  logic             pend_src;
  logic             pend_valid;
  logic [32:1]      disp_val;
  logic             disp_src;

  logic        tick;
  logic        boundary;
  logic [31:0] upper;
  logic [3:0]  nib;
  logic        blank;
  logic [8:1]  an_d;
  logic [8:1]  seg_d;

  // Segment pattern g..a, active low.
  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'b1000000;
      4'h1: hex7 = 7'b1111001;
      4'h2: hex7 = 7'b0100100;
      4'h3: hex7 = 7'b0110000;
      4'h4: hex7 = 7'b0011001;
      4'h5: hex7 = 7'b0010010;
      4'h6: hex7 = 7'b0000010;
      4'h7: hex7 = 7'b1111000;
      4'h8: hex7 = 7'b0000000;
      4'h9: hex7 = 7'b0010000;
      4'hA: hex7 = 7'b0001000;
      4'hB: hex7 = 7'b0000011;
      4'hC: hex7 = 7'b1000110;
      4'hD: hex7 = 7'b0100001;
      4'hE: hex7 = 7'b0000110;
      default: hex7 = 7'b0001110;
    endcase
  endfunction

  assign tick     = (div == DIV_LAST);
  assign boundary = tick && (idx == 3'd7);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div        <= '0;
      idx        <= '0;
      pend_val   <= '0;
      pend_src   <= 1'b0;
      pend_valid <= 1'b0;
      disp_val   <= '0;
      disp_src   <= 1'b0;
      frame_done <= 1'b0;
      an         <= 8'hFF;
      seg        <= 8'hFF;
    end else begin
      div        <= tick ? '0 : div + 1'b1;
      if (tick) idx <= idx + 3'd1;
      frame_done <= boundary;
      an         <= an_d;
      seg        <= seg_d;
      // Transfer uses the pending value from before this edge; a coincident load
      // re-arms pend below so it is shown at the next boundary.
      if (boundary && pend_valid) begin
        disp_val   <= pend_val;
        disp_src   <= pend_src;
        pend_valid <= 1'b0;
      end
      if (load) begin
        pend_val   <= src_sel ? data_b : data_a;
        pend_src   <= src_sel;
        pend_valid <= 1'b1;
      end
    end
  end

  // upper holds nibbles idx..7; zero there means idx is a leading-zero digit.
  always_comb begin
    upper = disp_val >> {idx, 2'b00};
    nib   = upper[3:0];
    blank = BLANK_LZ && (idx != 3'd0) && (upper == 32'd0);
    an_d  = ~(8'b1 << idx);
    seg_d = {~(disp_src && (idx == 3'd0)), hex7(nib)};
    if (blank) begin
      an_d  = 8'hFF;
      seg_d = 8'hFF;
    end
  end

endmodule

// File: tb/tb_seg7_scan_display.sv
// Directed bench for seg7_scan_display: table of captured values with hand-computed
// per-slot patterns, plus sequences for frame timing, boundary loads and async reset.
module tb_seg7_scan_display;

  logic        clk;
  logic        rst_n;
  logic        load;
  logic        src_sel;
  logic [32:1] data_a;
  logic [32:1] data_b;
  logic [8:1]  an, seg, an2, seg2;
  logic        frame_done, frame_done2;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] cap_an[8], cap_seg[8], cap_an2[8], cap_seg2[8];

  typedef struct {
    logic             two_loads;
    logic             src;
    logic [31:0]      da;
    logic [31:0]      db;
    logic [7:0][7:0]  ean;
    logic [7:0][7:0]  eseg;
    logic [7:0][7:0]  eseg2;
  } vec_t;

  vec_t vecs[6];
  localparam logic [7:0][7:0] AN_ALL = 64'h7FBFDFEFF7FBFDFE;

  seg7_scan_display #(.SCAN_DIV(4), .BLANK_LZ(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .load(load), .src_sel(src_sel),
    .data_a(data_a), .data_b(data_b), .an(an), .seg(seg), .frame_done(frame_done)
  );

  seg7_scan_display #(.SCAN_DIV(4), .BLANK_LZ(1'b0)) dut_nb (
    .clk(clk), .rst_n(rst_n), .load(load), .src_sel(src_sel),
    .data_a(data_a), .data_b(data_b), .an(an2), .seg(seg2), .frame_done(frame_done2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Returns at the negedge right after a boundary edge (frame_done high).
  task automatic wait_fd(input string nm);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      step();
      if (frame_done) begin
        seen = 1'b1;
        break;
      end
    end
    chk({nm, "_frame_done_seen"}, {31'd0, seen}, 32'd1);
  endtask

  // Called at the negedge after a boundary; samples each slot of the next frame.
  task automatic capture();
    for (int k = 0; k < 8; k++) begin
      repeat ((k == 0) ? 1 : 4) @(posedge clk);
      @(negedge clk);
      cap_an[k]   = an;
      cap_seg[k]  = seg;
      cap_an2[k]  = an2;
      cap_seg2[k] = seg2;
    end
  endtask

  initial begin
    int cnt;
    logic [7:0] prev_an7, prev_seg7;

    vecs[0] = '{1'b0, 1'b0, 32'h1234ABCD, 32'hFFFFFFFF,
                64'h7FBFDFEFF7FBFDFE, 64'hF9A4B0998883C6A1, 64'hF9A4B0998883C6A1};
    vecs[1] = '{1'b1, 1'b0, 32'h00000005, 32'h00000000,
                64'hFFFFFFFFFFFFFFFE, 64'hFFFFFFFFFFFFFF92, 64'hC0C0C0C0C0C0C092};
    vecs[2] = '{1'b0, 1'b0, 32'h000000F0, 32'h00000000,
                64'hFFFFFFFFFFFFFDFE, 64'hFFFFFFFFFFFF8EC0, 64'hC0C0C0C0C0C08EC0};
    vecs[3] = '{1'b0, 1'b1, 32'h12345678, 32'h00000008,
                64'hFFFFFFFFFFFFFFFE, 64'hFFFFFFFFFFFFFF00, 64'hC0C0C0C0C0C0C000};
    vecs[4] = '{1'b0, 1'b1, 32'hDEADBEEF, 32'h00A00000,
                64'hFFFFDFEFF7FBFDFE, 64'hFFFF88C0C0C0C040, 64'hC0C088C0C0C0C040};
    vecs[5] = '{1'b0, 1'b0, 32'h00000000, 32'h00001234,
                64'hFFFFFFFFFFFFFFFE, 64'hFFFFFFFFFFFFFFC0, 64'hC0C0C0C0C0C0C0C0};

    rst_n = 1'b0; load = 1'b0; src_sel = 1'b0; data_a = '0; data_b = '0;

    // Reset state
    repeat (3) step();
    chk("rst_an", an, 8'hFF);
    chk("rst_seg", seg, 8'hFF);
    chk("rst_fd", frame_done, 1'b0);
    rst_n = 1'b1;
    step();
    chk("first_an", an, 8'hFE);
    chk("first_seg", seg, 8'hC0);

    // Frame period and pulse width
    wait_fd("period_a");
    cnt = 0;
    do begin
      step();
      cnt++;
      if (cnt == 1) chk("fd_width", frame_done, 1'b0);
    end while (!frame_done && cnt < 100);
    chk("fd_period", cnt, 32);

    // Idle frame with disp_val = 0
    capture();
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("idle_an%0d", k), cap_an[k], (k == 0) ? 8'hFE : 8'hFF);
      chk($sformatf("idle_seg%0d", k), cap_seg[k], (k == 0) ? 8'hC0 : 8'hFF);
    end
    prev_an7  = 8'hFF;
    prev_seg7 = 8'hFF;

    // Table: load mid-frame (slot 7), display must hold until the boundary
    for (int v = 0; v < 6; v++) begin
      if (vecs[v].two_loads) begin
        load = 1'b1; src_sel = 1'b0; data_a = 32'h11111111;
        step();
      end
      load = 1'b1; src_sel = vecs[v].src; data_a = vecs[v].da; data_b = vecs[v].db;
      step();
      load = 1'b0;
      chk($sformatf("v%0d_hold_an", v), an, prev_an7);
      chk($sformatf("v%0d_hold_seg", v), seg, prev_seg7);
      wait_fd($sformatf("v%0d", v));
      capture();
      for (int k = 0; k < 8; k++) begin
        chk($sformatf("v%0d_an%0d", v, k), cap_an[k], vecs[v].ean[k]);
        chk($sformatf("v%0d_seg%0d", v, k), cap_seg[k], vecs[v].eseg[k]);
        chk($sformatf("v%0d_nb_an%0d", v, k), cap_an2[k], AN_ALL[k]);
        chk($sformatf("v%0d_nb_seg%0d", v, k), cap_seg2[k], vecs[v].eseg2[k]);
      end
      prev_an7  = vecs[v].ean[7];
      prev_seg7 = vecs[v].eseg[7];
    end

    // Load coinciding with the boundary edge while pend holds 3
    wait_fd("bnd_sync");
    load = 1'b1; src_sel = 1'b0; data_a = 32'h00000003;
    step();
    load = 1'b0;
    repeat (30) @(posedge clk);
    @(negedge clk);
    load = 1'b1; data_a = 32'h00000007;
    step();
    load = 1'b0;
    chk("bnd_fd", frame_done, 1'b1);
    step();
    chk("bnd_an_first", an, 8'hFE);
    chk("bnd_seg_first", seg, 8'hB0);
    wait_fd("bnd_next");
    step();
    chk("bnd_an_next", an, 8'hFE);
    chk("bnd_seg_next", seg, 8'hF8);

    // ALU source with dp, then asynchronous reset mid-slot
    load = 1'b1; src_sel = 1'b1; data_b = 32'h00000008; data_a = 32'h00000001;
    step();
    load = 1'b0; src_sel = 1'b0;
    wait_fd("dp");
    step();
    chk("dp_an", an, 8'hFE);
    chk("dp_seg", seg, 8'h00);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_an", an, 8'hFF);
    chk("arst_seg", seg, 8'hFF);
    chk("arst_fd", frame_done, 1'b0);
    chk("arst_nb_an", an2, 8'hFF);
    chk("arst_nb_seg", seg2, 8'hFF);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("post_an", an, 8'hFE);
    chk("post_seg", seg, 8'hC0);
    wait_fd("post_a");
    wait_fd("post_b");
    step();
    chk("post_hold_an", an, 8'hFE);
    chk("post_hold_seg", seg, 8'hC0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
